// File: rtl/demux14_4_fifo_if.sv
// Bundle of the source-side word/select handshake and the four sink-side channels
// of the 1-to-4 word demultiplexer.
interface demux14_4_fifo_if #(
    parameter int W = 4
);
    logic [W-1:0] w;
    logic [1:0]   s;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] y0;
    logic [W-1:0] y1;
    logic [W-1:0] y2;
    logic [W-1:0] y3;
    logic         v0;
    logic         v1;
    logic         v2;
    logic         v3;
    logic         r0;
    logic         r1;
    logic         r2;
    logic         r3;
    logic         busy;

    modport slave (
        input  w, s, in_valid, r0, r1, r2, r3,
        output in_ready, y0, y1, y2, y3, v0, v1, v2, v3, busy
    );

    modport master (
        output w, s, in_valid, r0, r1, r2, r3,
        input  in_ready, y0, y1, y2, y3, v0, v1, v2, v3, busy
    );
endinterface

// File: rtl/demux14_4_fifo.sv
// 1-to-4 word demultiplexer: each word is steered by s into one of four small
// per-channel FIFOs, each drained by its own valid/ready sink.
module demux14_4_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    demux14_4_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("demux14_4_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [W-1:0]  mem_q    [4][DEPTH];
    logic [W-1:0]  mem_d    [4][DEPTH];
    logic [AW-1:0] wr_ptr_q [4];
    logic [AW-1:0] wr_ptr_d [4];
    logic [AW-1:0] rd_ptr_q [4];
    logic [AW-1:0] rd_ptr_d [4];
    logic [CW-1:0] cnt_q    [4];
    logic [CW-1:0] cnt_d    [4];

    logic [3:0]    rdy_vec;
    logic [3:0]    vld_vec;
    logic [3:0]    push_vec;
    logic [3:0]    pop_vec;
    logic [W-1:0]  head     [4];
    logic          in_ready_c;

    assign rdy_vec = {bus.r3, bus.r2, bus.r1, bus.r0};

    // Readiness looks only at the selected channel's registered count, so a full
    // channel never takes a word even when it pops in the same cycle.
    assign in_ready_c = (cnt_q[bus.s] != FULL_CNT);

    always_comb begin
        vld_vec = '0;
        for (int n = 0; n < 4; n++) begin
            vld_vec[n] = (cnt_q[n] != '0);
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        push_vec = '0;
        pop_vec  = '0;
        for (int n = 0; n < 4; n++) begin
            push_vec[n] = bus.in_valid && in_ready_c && (bus.s == 2'(n));
            pop_vec[n]  = vld_vec[n] && rdy_vec[n];

            if (push_vec[n]) begin
                mem_d[n][wr_ptr_q[n]] = bus.w;
                wr_ptr_d[n]           = wr_ptr_q[n] + AW'(1);
            end
            if (pop_vec[n]) begin
                rd_ptr_d[n] = rd_ptr_q[n] + AW'(1);
            end

            case ({push_vec[n], pop_vec[n]})
                2'b10:   cnt_d[n] = cnt_q[n] + CW'(1);
                2'b01:   cnt_d[n] = cnt_q[n] - CW'(1);
                default: cnt_d[n] = cnt_q[n];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 4; n++) begin
                wr_ptr_q[n] <= '0;
                rd_ptr_q[n] <= '0;
                cnt_q[n]    <= '0;
                for (int e = 0; e < DEPTH; e++) begin
                    mem_q[n][e] <= '0;
                end
            end
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Empty channels present zero rather than stale storage.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            head[n] = vld_vec[n] ? mem_q[n][rd_ptr_q[n]] : '0;
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.y0       = head[0];
    assign bus.y1       = head[1];
    assign bus.y2       = head[2];
    assign bus.y3       = head[3];
    assign bus.v0       = vld_vec[0];
    assign bus.v1       = vld_vec[1];
    assign bus.v2       = vld_vec[2];
    assign bus.v3       = vld_vec[3];
    assign bus.busy     = |vld_vec;
endmodule

// File: tb/tb_demux14_4_fifo.sv
// Scoreboard bench for demux14_4_fifo: per-channel expected-word queues track every
// accepted push and are compared against the channel heads each cycle.
module tb_demux14_4_fifo;
    localparam int W     = 4;
    localparam int DEPTH = 2;

    logic clk;
    logic rst_n;
    logic [3:0] rv;

    demux14_4_fifo_if #(.W(W)) bus ();

    demux14_4_fifo #(.W(W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.r0 = rv[0];
    assign bus.r1 = rv[1];
    assign bus.r2 = rv[2];
    assign bus.r3 = rv[3];

    wire [3:0]   v_vec = {bus.v3, bus.v2, bus.v1, bus.v0};
    wire [W-1:0] y_arr [4];
    assign y_arr[0] = bus.y0;
    assign y_arr[1] = bus.y1;
    assign y_arr[2] = bus.y2;
    assign y_arr[3] = bus.y3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q [4][$];
    logic [W-1:0] out1  [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: heads/valids compared mid-cycle, then queues advanced for the coming edge.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [W-1:0] popped;
            logic acc;
            for (int n = 0; n < 4; n++) begin
                check_eq($sformatf("v%0d", n), 32'(v_vec[n]), 32'(exp_q[n].size() != 0));
                check_eq($sformatf("y%0d", n), 32'(y_arr[n]),
                         (exp_q[n].size() != 0) ? 32'(exp_q[n][0]) : 32'h0);
            end
            check_eq("busy", 32'(bus.busy),
                     32'((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0));
            check_eq("in_ready", 32'(bus.in_ready), 32'(exp_q[bus.s].size() < DEPTH));
            acc = bus.in_valid && (exp_q[bus.s].size() < DEPTH);
            for (int n = 0; n < 4; n++) begin
                if (exp_q[n].size() != 0 && rv[n]) begin
                    popped = exp_q[n].pop_front();
                    if (n == 1) out1.push_back(popped);
                end
            end
            if (acc) exp_q[bus.s].push_back(bus.w);
        end
    end

    task automatic step(input logic iv, input logic [W-1:0] iw, input logic [1:0] is,
                        input logic [3:0] ir);
        bus.in_valid = iv;
        bus.w        = iv ? iw : W'($urandom);
        bus.s        = iv ? is : 2'($urandom);
        rv           = ir;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int n = 0; n < 4; n++) exp_q[n].delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int i;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.w        = '0;
        bus.s        = '0;
        rv           = '0;

        #3;
        check_eq("rst_busy", 32'(bus.busy), 32'h0);
        for (int n = 0; n < 4; n++) begin
            check_eq($sformatf("rst_v%0d", n), 32'(v_vec[n]), 32'h0);
            check_eq($sformatf("rst_y%0d", n), 32'(y_arr[n]), 32'h0);
            bus.s = 2'(n);
            #1 check_eq($sformatf("rst_in_ready_s%0d", n), 32'(bus.in_ready), 32'h1);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single push after reset release
        step(1'b1, 4'h1, 2'd0, 4'b0000);
        check_eq("first_v0", 32'(bus.v0), 32'h1);
        check_eq("first_y0", 32'(bus.y0), 32'h1);
        check_eq("first_busy", 32'(bus.busy), 32'h1);
        check_eq("first_v123", 32'({bus.v3, bus.v2, bus.v1}), 32'h0);

        // Routing
        step(1'b1, 4'h2, 2'd1, 4'b0000);
        step(1'b1, 4'h3, 2'd2, 4'b0000);
        step(1'b1, 4'hE, 2'd3, 4'b0000);
        check_eq("route_y1", 32'(bus.y1), 32'h2);
        check_eq("route_y2", 32'(bus.y2), 32'h3);
        check_eq("route_y3", 32'(bus.y3), 32'hE);
        check_eq("route_v", 32'(v_vec), 32'hF);
        step(1'b0, 4'h0, 2'd0, 4'b1111);
        check_eq("route_drain_busy", 32'(bus.busy), 32'h0);

        // Full channel back-pressure
        step(1'b1, 4'hA, 2'd0, 4'b0000);
        step(1'b1, 4'hB, 2'd0, 4'b0000);
        bus.in_valid = 1'b1;
        bus.w        = 4'hC;
        bus.s        = 2'd0;
        #1 check_eq("full_in_ready_s0", 32'(bus.in_ready), 32'h0);
        bus.in_valid = 1'b0;
        bus.s        = 2'd1;
        #1 check_eq("full_in_ready_s1", 32'(bus.in_ready), 32'h1);
        check_eq("full_y0_head", 32'(bus.y0), 32'hA);
        step(1'b0, 4'h0, 2'd0, 4'b0001);
        check_eq("full_y0_next", 32'(bus.y0), 32'hB);
        bus.s = 2'd0;
        #1 check_eq("full_in_ready_again", 32'(bus.in_ready), 32'h1);
        step(1'b0, 4'h0, 2'd0, 4'b1111);

        // Streaming through channel 2
        for (int k = 0; k < 14; k++) begin
            step(1'b1, 4'(k), 2'd2, 4'b0100);
            check_eq($sformatf("stream_v2_%0d", k), 32'(bus.v2), 32'h1);
            check_eq($sformatf("stream_y2_%0d", k), 32'(bus.y2), 32'(k));
            check_eq($sformatf("stream_rdy_%0d", k), 32'(bus.in_ready), 32'h1);
        end
        step(1'b0, 4'h0, 2'd0, 4'b0100);
        check_eq("stream_empty", 32'(bus.v2), 32'h0);

        // Reset in the middle of operation
        step(1'b1, 4'h5, 2'd0, 4'b0000);
        step(1'b1, 4'h6, 2'd0, 4'b0000);
        step(1'b1, 4'h7, 2'd3, 4'b0000);
        step(1'b1, 4'h8, 2'd3, 4'b0000);
        bus.in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_eq("midrst_v", 32'(v_vec), 32'h0);
        check_eq("midrst_y0", 32'(bus.y0), 32'h0);
        check_eq("midrst_y3", 32'(bus.y3), 32'h0);
        check_eq("midrst_busy", 32'(bus.busy), 32'h0);
        clear_model();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 4'h0, 2'd0, 4'b1001);
            check_eq($sformatf("postrst_v0_%0d", k), 32'(bus.v0), 32'h0);
            check_eq($sformatf("postrst_v3_%0d", k), 32'(bus.v3), 32'h0);
        end

        // Pointer wrap with a toggling sink
        out1.delete();
        i   = 1;
        cyc = 0;
        while (i <= 9 && cyc < 100) begin
            logic ok;
            bus.in_valid = 1'b1;
            bus.w        = 4'(i);
            bus.s        = 2'd1;
            rv           = {2'b00, cyc[0], 1'b0};
            #2 ok = bus.in_ready;
            @(posedge clk);
            #1;
            if (ok) i++;
            cyc++;
        end
        check_eq("wrap_timeout", 32'(i), 32'd10);
        for (int k = 0; k < 8; k++) step(1'b0, 4'h0, 2'd0, 4'b0010);
        check_eq("wrap_count", 32'(out1.size()), 32'd9);
        for (int k = 0; k < out1.size() && k < 9; k++) begin
            check_eq($sformatf("wrap_order_%0d", k), 32'(out1[k]), 32'(k + 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/demux14_4_fifo.md
Name: demux14_4_fifo

Overview:
- 1-to-4 demultiplexer for 4-bit words; the routing counterpart of the 4:1 word mux.
- Each incoming word is steered by a 2-bit select `s` into one of four output channels.
- Each channel has a small FIFO and a valid/ready handshake, so a stalled consumer back-pressures only the producer targeting that channel.
- Sits between a single word source and four independent sinks.

Parameters:
- W, 4: data word width in bits.
- DEPTH, 2: entries per channel FIFO. Must be a power of two and at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- w  input  W  input data word.
- s  input  2  destination channel select.
- in_valid  input  1  w/s valid.
- in_ready  output  1  block can accept a word for channel s.
- y0, y1, y2, y3  output  W each  head word of channel 0..3.
- v0, v1, v2, v3  output  1 each  channel 0..3 holds a word.
- r0, r1, r2, r3  input  1 each  sink 0..3 accepts head word.
- busy  output  1  any channel non-empty.

Behaviour:
- **Reset:**
  - Reset is asynchronous, active-low, and has immediate effect; one clock; clk and rst_n.
  - While rst_n=0: all FIFO pointers and occupancy counts are 0, all storage is cleared to 0, v0..v3=0, y0..y3=0, busy=0.
  - in_ready=1 (all channels empty).
  - Reset asserted mid-transfer discards all stored words. Nothing is emitted after release until a new push.
- **Push:**
  - Occurs on a rising edge when in_valid=1 and in_ready=1.
  - The word w is written to the tail of FIFO[s] and count[s] increments.
- **in_ready:**
  - in_ready = ~full[s], where full[s] means count[s]==DEPTH.
  - It is combinational from s and registered state only; it does not depend on in_valid or r0..r3.
  - A full channel does not accept a push in the same cycle it pops (no pass-through).
- **Pop:**
  - Channel n pops on a rising edge when vn=1 and rn=1.
  - The head pointer advances and count[n] decrements.
  - rn while vn=0 is ignored; no underflow.
- **Outputs:**
  - vn = (count[n]!=0).
  - yn = head word when vn=1. yn = 0 when vn=0, forced combinationally.
- **Latency:**
  - A word pushed at edge k is visible on yn with vn=1 from just after edge k.
  - The channel sustains one push and one pop per cycle with no bubbles.
- **Simultaneous events on one channel (not full):** push and pop in the same cycle leave count unchanged. The pushed word lands behind the remaining contents; if the FIFO held one word, the new word becomes head.
- **Independence:** pushes to channel a and pops on channels b, c, d occur in the same cycle independently. Ordering is FIFO per channel; no ordering exists across channels.
- **Pointers:** pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits, range 0..DEPTH.
- **busy:** busy = v0|v1|v2|v3.
- **Select changes:** a change of s while in_valid=1 and in_ready=0 is legal. in_ready re-evaluates for the new s in the same cycle.
- **X handling:** when in_valid=0, w and s are don't-care and state does not change.

Test Plan:
- **Reset release, single push:** release reset; push w=4'h1, s=0 with r0=0 → after the edge v0=1, y0=4'h1, busy=1, v1..v3=0, y1..y3=0.
- **Routing:** push 4'h2→s=1, 4'h3→s=2, 4'hE→s=3 on consecutive cycles with all r=0 → y1=2, y2=3, y3=E, all v=1. Then assert all r for one cycle → all v=0, busy=0.
- **Full and back-pressure:** r0=0; push 4'hA, 4'hB to s=0 → in_ready=0 for s=0. Switch s=1 → in_ready=1. Pulse r0 → y0 goes A→B, and in_ready returns to 1 for s=0.
- **Streaming:** r2=1 held; push 4'h0..4'hD to s=2 every cycle → y2 follows each word one edge later, v2 never drops, count never exceeds 1, no stall.
- **Reset mid-operation:** fill channels 0 and 3 (2 words each); assert rst_n=0 between edges → v0..v3 and y outputs are 0 immediately, with no clock edge needed. After release, r0=r3=1 for 3 cycles → no words emerge.
- **Wrap-around:** with r1 toggling 0/1 each cycle, push 4'h1..4'h9 to s=1 over ≥10 cycles → output order is 1..9 exactly; pointers wrap several times with no loss or duplication.
